// File: rtl/scan_muxer_pkg.sv
// Shared definitions for the scan_muxer family: mode encodings and index-width helper.
package scan_muxer_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Ceiling log2, never below 1 so a 2-channel mux still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_next_finder.sv
// Round-robin next-index search: lowest set mask bit strictly after the cursor, wrapping mod N.
module rr_next_finder
  import scan_muxer_pkg::*;
#(
  parameter  int unsigned N  = 16,
  localparam int unsigned SW = clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [SW-1:0] cursor_i,
  output logic          found_o,
  output logic [SW-1:0] idx_o
);

  logic [N-1:0] rot;
  int unsigned  start;
  int unsigned  off;

  // Operands stay below 2N, so one conditional subtract is a full modulo.
  function automatic logic [SW-1:0] wrap(input int unsigned v);
    return SW'((v >= N) ? v - N : v);
  endfunction

  always_comb begin
    start   = (32'(cursor_i) + 1 >= N) ? 0 : 32'(cursor_i) + 1;
    rot     = '0;
    found_o = 1'b0;
    off     = 0;
    // Rotate so rot[0] is the slot just after the cursor; the cursor itself lands at rot[N-1].
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = mask_i[wrap(start + i)];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_o && rot[i]) begin
        found_o = 1'b1;
        off     = i;
      end
    end
    idx_o = wrap(start + off);
  end

endmodule

// File: rtl/scan_muxer.sv
// Registered N-to-1 channel mux with direct/scan selection and a valid/ready output stage.
module scan_muxer
  import scan_muxer_pkg::*;
#(
  parameter  int unsigned N  = 16,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = clog2(N)
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic [N*W-1:0] x_i,
  input  logic [SW-1:0]  b_i,
  input  logic           mode_i,
  input  logic [N-1:0]   mask_i,
  input  logic           run_i,
  input  logic           ready_i,
  output logic [W-1:0]   z_o,
  output logic [SW-1:0]  zch_o,
  output logic           valid_o,
  output logic           err_o
);

  localparam int unsigned XW = clog2(N * W);

  logic [W-1:0]  z_q, z_d;
  logic [SW-1:0] zch_q, zch_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [SW-1:0] cur_q, cur_d;

  logic          free;
  logic          load_req;
  logic          is_scan;
  logic          b_ok;
  logic          hit;
  logic          scan_found;
  logic [SW-1:0] scan_idx;
  logic [SW-1:0] sel;
  logic [XW-1:0] base;
  logic [W-1:0]  chan;

  rr_next_finder #(
    .N(N)
  ) u_finder (
    .mask_i   (mask_i),
    .cursor_i (cur_q),
    .found_o  (scan_found),
    .idx_o    (scan_idx)
  );

  always_comb begin
    free     = ~valid_q | ready_i;
    load_req = run_i & free;
    is_scan  = (mode_i == MODE_SCAN);
    b_ok     = 32'(b_i) < N;
    sel      = is_scan ? scan_idx : b_i;
    hit      = is_scan ? scan_found : b_ok;
    base     = XW'(sel) * XW'(W);
    // Out-of-range base only occurs for a rejected direct command, so chan is unused then.
    chan     = x_i[base +: W];

    z_d     = z_q;
    zch_d   = zch_q;
    valid_d = valid_q;
    err_d   = err_q;
    cur_d   = cur_q;

    if (load_req) begin
      valid_d = hit;
      if (hit) begin
        z_d   = chan;
        zch_d = sel;
        if (is_scan) cur_d = scan_idx;
      end else if (!is_scan) begin
        err_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      z_q     <= '0;
      zch_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cur_q   <= SW'(N - 1);
    end else begin
      z_q     <= z_d;
      zch_q   <= zch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cur_q   <= cur_d;
    end
  end

  assign z_o     = z_q;
  assign zch_o   = zch_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_scan_muxer.sv
// Bench for scan_muxer: cycle-by-cycle reference model on a 16-channel instance plus directed
// literal checks on 16- and 12-channel instances.
module tb_scan_muxer;
  import scan_muxer_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned N2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, mode, run, ready;
  logic [127:0] x;
  logic [3:0]   b;
  logic [15:0]  mask;
  logic [7:0]   z;
  logic [3:0]   zch;
  logic         valid, err;

  logic         rst2, mode2, run2, ready2;
  logic [95:0]  x2;
  logic [3:0]   b2;
  logic [11:0]  mask2;
  logic [7:0]   z2;
  logic [3:0]   zch2;
  logic         valid2, err2;

  scan_muxer #(.N(N), .W(8)) dut (
    .clock_i (clk),   .reset_i (rst),   .x_i   (x),     .b_i     (b),
    .mode_i  (mode),  .mask_i  (mask),  .run_i (run),   .ready_i (ready),
    .z_o     (z),     .zch_o   (zch),   .valid_o (valid), .err_o (err)
  );

  scan_muxer #(.N(N2), .W(8)) dut12 (
    .clock_i (clk),   .reset_i (rst2),  .x_i   (x2),    .b_i     (b2),
    .mode_i  (mode2), .mask_i  (mask2), .run_i (run2),  .ready_i (ready2),
    .z_o     (z2),    .zch_o   (zch2),  .valid_o (valid2), .err_o (err2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_x(input int base_val);
    for (int k = 0; k < 16; k++) x[k*8 +: 8] = 8'(base_val + k);
  endtask

  // Reference model: applies the selection rules directly, searching by modular arithmetic.
  logic [7:0] m_z;
  int         m_zch, m_cur, c;
  bit         m_valid, m_err, m_got;
  bit         m_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_z = 8'h00; m_zch = 0; m_valid = 1'b0; m_err = 1'b0; m_cur = N - 1; m_on = 1'b1;
    end else if (m_on && (!m_valid || ready)) begin
      m_got = 1'b0;
      if (run) begin
        if (mode) begin
          for (int k = 1; k <= int'(N); k++) begin
            c = (m_cur + k) % N;
            if (!m_got && mask[c]) begin
              m_got = 1'b1; m_cur = c; m_zch = c; m_z = x[c*8 +: 8];
            end
          end
        end else if (32'(b) < N) begin
          m_got = 1'b1; m_zch = int'(b); m_z = x[int'(b)*8 +: 8];
        end else begin
          m_err = 1'b1;
        end
      end
      m_valid = m_got;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_z", 32'(z), 32'(m_z));
      chk("model_zch", 32'(zch), 32'(m_zch));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_err", 32'(err), 32'(m_err));
    end
  end

  int seq[6];

  initial begin
    rst = 1'b1; run = 1'b0; ready = 1'b0; mode = MODE_DIRECT; b = 4'd0; mask = 16'h0;
    fill_x(8'h10);
    rst2 = 1'b1; run2 = 1'b0; ready2 = 1'b0; mode2 = MODE_DIRECT; b2 = 4'd0; mask2 = 12'h0;
    for (int k = 0; k < 12; k++) x2[k*8 +: 8] = 8'(8'h30 + k);
    cyc(); cyc();

    chk("reset_z", 32'(z), 32'h0);
    chk("reset_zch", 32'(zch), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset12_valid", 32'(valid2), 32'h0);
    chk("reset12_err", 32'(err2), 32'h0);

    // Direct mode sweep.
    rst = 1'b0; mode = MODE_DIRECT; run = 1'b1; ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      cyc();
      chk("direct_z", 32'(z), 32'(8'h10 + i));
      chk("direct_zch", 32'(zch), 32'(i));
      chk("direct_valid", 32'(valid), 32'h1);
    end

    // Scan with a sparse mask from reset, then mask cleared.
    rst = 1'b1; cyc();
    rst = 1'b0; mode = MODE_SCAN; mask = 16'h0085;
    seq = '{0, 2, 7, 0, 2, 7};
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("scan_zch", 32'(zch), 32'(seq[i]));
      chk("scan_z", 32'(z), 32'(8'h10 + seq[i]));
    end
    mask = 16'h0000;
    cyc();
    chk("scan_empty_valid", 32'(valid), 32'h0);
    chk("scan_empty_zch", 32'(zch), 32'd7);
    cyc();
    chk("scan_empty_valid2", 32'(valid), 32'h0);

    // Backpressure: hold channel 0 while x changes, then release.
    rst = 1'b1; cyc();
    rst = 1'b0; mask = 16'hFFFF; ready = 1'b0;
    cyc();
    chk("bp_first_zch", 32'(zch), 32'd0);
    chk("bp_first_valid", 32'(valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      fill_x(8'h50 + i);
      cyc();
      chk("bp_hold_z", 32'(z), 32'h10);
      chk("bp_hold_zch", 32'(zch), 32'd0);
    end
    fill_x(8'h50);
    ready = 1'b1;
    cyc();
    chk("bp_release_zch", 32'(zch), 32'd1);
    chk("bp_release_z", 32'(z), 32'h51);
    fill_x(8'h10);

    // Mode switch keeps the scan cursor.
    rst = 1'b1; cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("switch_scan_zch", 32'(zch), 32'(i));
    end
    mode = MODE_DIRECT; b = 4'd9;
    cyc();
    chk("switch_direct_zch", 32'(zch), 32'd9);
    chk("switch_direct_z", 32'(z), 32'h19);
    mode = MODE_SCAN;
    cyc();
    chk("switch_back_zch", 32'(zch), 32'd3);
    chk("switch_back_z", 32'(z), 32'h13);

    // Reset while a sample is pending.
    ready = 1'b0;
    cyc();
    chk("pending_valid", 32'(valid), 32'h1);
    rst = 1'b1;
    cyc();
    chk("midrst_z", 32'(z), 32'h0);
    chk("midrst_zch", 32'(zch), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    rst = 1'b0; mask = 16'h8000; ready = 1'b1;
    cyc();
    chk("after_rst_zch", 32'(zch), 32'd15);
    chk("after_rst_z", 32'(z), 32'h1F);
    cyc();
    chk("single_repeat_zch", 32'(zch), 32'd15);
    run = 1'b0;

    // 12-channel instance: out-of-range command and wrap at a non-power-of-two N.
    rst2 = 1'b0; mode2 = MODE_DIRECT; run2 = 1'b1; ready2 = 1'b1; b2 = 4'd13;
    cyc();
    chk("oor_err", 32'(err2), 32'h1);
    chk("oor_valid", 32'(valid2), 32'h0);
    chk("oor_zch", 32'(zch2), 32'h0);
    b2 = 4'd5;
    cyc();
    chk("oor_next_z", 32'(z2), 32'h35);
    chk("oor_next_zch", 32'(zch2), 32'd5);
    chk("oor_next_valid", 32'(valid2), 32'h1);
    chk("oor_sticky_err", 32'(err2), 32'h1);
    rst2 = 1'b1; cyc();
    chk("n12_rst_err", 32'(err2), 32'h0);
    rst2 = 1'b0; mode2 = MODE_SCAN; mask2 = 12'h800;
    cyc();
    chk("n12_scan_zch", 32'(zch2), 32'd11);
    chk("n12_scan_z", 32'(z2), 32'h3B);
    mask2 = 12'h801;
    cyc();
    chk("n12_wrap_zch", 32'(zch2), 32'd0);
    run2 = 1'b0;
    cyc();
    chk("n12_drain_valid", 32'(valid2), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
